led_scanner: RTL

- Parametrised next-generation Knight Rider LED scanner for Red Pitaya LED banks.
- A single moving head walks across N_LEDS outputs at a programmable rate, with bounce, wrap-up, wrap-down and hold modes.
- A PWM-dimmed fading tail trails the head.
- Sits between a register bank or constant drivers and the board LED pins.

---
 rtl/led_scanner_pkg.sv | 16 +
 rtl/led_pwm_channel.sv | 37 +++
 rtl/led_scanner.sv | 128 ++++++++++++
 3 files changed

// File: rtl/led_scanner_pkg.sv
// Shared definitions for the LED scanner: mode encodings and
// the head-index width helper.
package led_scanner_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE  = 2'd0,
        MODE_WRAP_UP = 2'd1,
        MODE_WRAP_DN = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_e;

    function automatic int pos_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED of the scanner: brightness level with load/decay
// and a registered compare against the shared PWM counter.
module led_pwm_channel
    import led_scanner_pkg::*;
#(
    parameter int PWM_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             shift,
    input  logic             load,
    input  logic             en,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             led
);

    logic [PWM_W-1:0] lvl;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lvl <= '0;
            led <= 1'b0;
        end else begin
            if (clear) begin
                lvl <= '0;
            end else if (load) begin
                lvl <= '1;
            end else if (shift) begin
                lvl <= lvl >> 1;
            end
            // A restart darkens the pin at once rather than a cycle late.
            led <= en & ~clear & (lvl > pwm_cnt);
        end
    end

endmodule

// File: rtl/led_scanner.sv
// Knight Rider style LED scanner: prescaled moving head with
// bounce/wrap/hold modes and a PWM-dimmed fading tail.
module led_scanner
    import led_scanner_pkg::*;
#(
    parameter  int N_LEDS  = 8,
    parameter  int PRESC_W = 24,
    parameter  int PWM_W   = 4,
    localparam int POS_W   = pos_width(N_LEDS)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic               restart,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] div,
    output logic [N_LEDS-1:0]  led_out,
    output logic [POS_W-1:0]   pos,
    output logic               dir,
    output logic               step
);

    localparam logic [PWM_W-1:0] MAXL = '1;
    localparam logic [PWM_W-1:0] PWM_TOP = MAXL - PWM_W'(1);
    localparam logic [POS_W-1:0] LAST = POS_W'(N_LEDS - 1);

    logic [PRESC_W-1:0] presc_cnt;
    logic [PWM_W-1:0]   pwm_cnt;
    logic               step_int;
    logic [POS_W-1:0]   pos_nxt;
    logic               dir_nxt;
    mode_e              mode_sel;

    assign mode_sel = mode_e'(mode);
    // >= so that lowering div below the running count fires at once.
    assign step_int = en & (presc_cnt >= div);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc_cnt <= '0;
        end else if (restart || step_int) begin
            presc_cnt <= '0;
        end else if (en) begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt >= PWM_TOP) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        if (N_LEDS > 1) begin
            unique case (mode_sel)
                MODE_BOUNCE: begin
                    if (dir && pos == LAST) begin
                        dir_nxt = 1'b0;
                        pos_nxt = LAST - POS_W'(1);
                    end else if (!dir && pos == '0) begin
                        dir_nxt = 1'b1;
                        pos_nxt = POS_W'(1);
                    end else if (dir) begin
                        pos_nxt = pos + POS_W'(1);
                    end else begin
                        pos_nxt = pos - POS_W'(1);
                    end
                end
                MODE_WRAP_UP: begin
                    dir_nxt = 1'b1;
                    pos_nxt = (pos == LAST) ? '0 : pos + POS_W'(1);
                end
                MODE_WRAP_DN: begin
                    dir_nxt = 1'b0;
                    pos_nxt = (pos == '0) ? LAST : pos - POS_W'(1);
                end
                MODE_HOLD: begin
                    pos_nxt = pos;
                    dir_nxt = dir;
                end
                default: begin
                    pos_nxt = pos;
                    dir_nxt = dir;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pos  <= '0;
            dir  <= 1'b1;
            step <= 1'b0;
        end else begin
            step <= step_int & ~restart;
            if (restart) begin
                pos <= '0;
                dir <= 1'b1;
            end else if (step_int) begin
                pos <= pos_nxt;
                dir <= dir_nxt;
            end
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_W(PWM_W)
        ) u_ch (
            .clk    (clk),
            .rstn   (rstn),
            .clear  (restart),
            .shift  (step_int),
            .load   (step_int && (pos_nxt == POS_W'(i))),
            .en     (en),
            .pwm_cnt(pwm_cnt),
            .led    (led_out[i])
        );
    end

endmodule
